// File: rtl/vme_request_decoder_pkg.sv
// Shared constants and types for the VME request decoder slice.
// Holds signal levels, FSM/space encodings, function codes and window defaults.
package vme_request_decoder_pkg;

  localparam logic LVL_ACTIVE   = 1'b0;
  localparam logic LVL_INACTIVE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_BERR,
    S_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_A16,
    SP_A24,
    SP_A40
  } space_t;

  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  localparam logic [15:0] A16_TOP_DEF = 16'hFFFF;
  localparam logic [7:0]  A24_TOP_DEF = 8'hFE;
  localparam logic        A40_TOP_DEF = 1'b1;
  localparam int          TIMEOUT_DEF = 1024;
  localparam int          CNT_W_DEF   = 11;

  // Windows overlap, so the order below is the priority.
  function automatic space_t decode_space(
    input logic [31:0] addr,
    input logic [15:0] a16_top,
    input logic [7:0]  a24_top,
    input logic        a40_top
  );
    space_t sp;
    sp = SP_NONE;
    if (addr[31:16] == a16_top)
      sp = SP_A16;
    else if (addr[31:24] == a24_top)
      sp = SP_A24;
    else if (addr[31] == a40_top)
      sp = SP_A40;
    return sp;
  endfunction

endpackage

// File: rtl/vme_request_decoder_bus_watchdog.sv
// Bus-cycle watchdog: counts enabled clocks since clear.
// Ports: clock, reset, clear, enable in; expired out (count reached limit).
module vme_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (enable && count != MAX)
      count <= count + CNT_W'(1);
  end

  // Combinational so the owner can act on the same edge;
  // it is one cycle wide because the owner leaves ACTIVE.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/vme_request_decoder.sv
// Decodes CPU bus cycles into A16/A24/A40 VME requests and runs the
// DSACK watchdog that raises BERR and records the faulting address.
module vme_request_decoder
  import vme_request_decoder_pkg::*;
#(
  parameter logic [15:0] A16_TOP        = A16_TOP_DEF,
  parameter logic [7:0]  A24_TOP        = A24_TOP_DEF,
  parameter logic        A40_TOP        = A40_TOP_DEF,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int          CNT_W          = CNT_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_as,
  input  logic [2:0]  cpu_fc,
  input  logic [31:0] cpu_address,
  input  logic [1:0]  dsack_in,
  output logic        request_vme_a16,
  output logic        request_vme_a24,
  output logic        request_vme_a40,
  output logic        cpu_berr,
  output logic        timeout_flag,
  output logic [31:0] timeout_address,
  input  logic        timeout_clear
);

  state_t state;
  space_t space;
  logic   as_prev;
  logic   wd_clear;
  logic   wd_enable;
  logic   expired;

  assign space = decode_space(
    cpu_address, A16_TOP, A24_TOP, A40_TOP);

  assign wd_clear  = (state != S_ACTIVE);
  assign wd_enable = (state == S_ACTIVE)
                  && !cpu_as
                  && (dsack_in == 2'b11);

  vme_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      as_prev         <= 1'b0;
      request_vme_a16 <= LVL_INACTIVE;
      request_vme_a24 <= LVL_INACTIVE;
      request_vme_a40 <= LVL_INACTIVE;
      cpu_berr        <= LVL_INACTIVE;
      timeout_flag    <= 1'b0;
      timeout_address <= '0;
    end else begin
      as_prev <= cpu_as;
      // A timeout in the same clock overrides this below.
      if (timeout_clear)
        timeout_flag <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Launch only on a falling strobe, so an
          // AS held low into IDLE cannot restart.
          if (!cpu_as && as_prev) begin
            if (cpu_fc == FC_CPU_SPACE) begin
              state <= S_RELEASE;
            end else begin
              unique case (space)
                SP_A16: begin
                  request_vme_a16 <= LVL_ACTIVE;
                  state           <= S_ACTIVE;
                end
                SP_A24: begin
                  request_vme_a24 <= LVL_ACTIVE;
                  state           <= S_ACTIVE;
                end
                SP_A40: begin
                  request_vme_a40 <= LVL_ACTIVE;
                  state           <= S_ACTIVE;
                end
                default: state <= S_RELEASE;
              endcase
            end
          end
        end
        S_ACTIVE: begin
          if (cpu_as) begin
            request_vme_a16 <= LVL_INACTIVE;
            request_vme_a24 <= LVL_INACTIVE;
            request_vme_a40 <= LVL_INACTIVE;
            state           <= S_IDLE;
          end else if (expired) begin
            request_vme_a16 <= LVL_INACTIVE;
            request_vme_a24 <= LVL_INACTIVE;
            request_vme_a40 <= LVL_INACTIVE;
            cpu_berr        <= LVL_ACTIVE;
            timeout_flag    <= 1'b1;
            timeout_address <= cpu_address;
            state           <= S_BERR;
          end
        end
        S_BERR: begin
          if (cpu_as) begin
            cpu_berr <= LVL_INACTIVE;
            state    <= S_IDLE;
          end
        end
        S_RELEASE: begin
          if (cpu_as)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_request_decoder.sv
// Directed self-checking bench for vme_request_decoder.
// Drives and samples 1 time unit after each rising clock edge.
module tb_vme_request_decoder;

  localparam int TO = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_as;
  logic [2:0]  cpu_fc;
  logic [31:0] cpu_address;
  logic [1:0]  dsack_in;
  logic        request_vme_a16;
  logic        request_vme_a24;
  logic        request_vme_a40;
  logic        cpu_berr;
  logic        timeout_flag;
  logic [31:0] timeout_address;
  logic        timeout_clear;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  vme_request_decoder dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_as          (cpu_as),
    .cpu_fc          (cpu_fc),
    .cpu_address     (cpu_address),
    .dsack_in        (dsack_in),
    .request_vme_a16 (request_vme_a16),
    .request_vme_a24 (request_vme_a24),
    .request_vme_a40 (request_vme_a40),
    .cpu_berr        (cpu_berr),
    .timeout_flag    (timeout_flag),
    .timeout_address (timeout_address),
    .timeout_clear   (timeout_clear)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] reqs();
    return {29'd0, request_vme_a16,
            request_vme_a24, request_vme_a40};
  endfunction

  task automatic start(input logic [2:0] fc,
                       input logic [31:0] a);
    cpu_fc      = fc;
    cpu_address = a;
    cpu_as      = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    cpu_as        = 1'b1;
    cpu_fc        = 3'b000;
    cpu_address   = '0;
    dsack_in      = 2'b11;
    timeout_clear = 1'b0;
    tick(2);
    check("rst_req",   reqs(), 32'h7);
    check("rst_berr",  32'(cpu_berr), 32'h1);
    check("rst_flag",  32'(timeout_flag), 32'h0);
    check("rst_taddr", timeout_address, 32'h0);
    reset = 1'b0;
    tick(1);

    // A24 read with DSACK at +5
    start(3'b101, 32'hFE001234);
    tick(1);
    check("a24_req", reqs(), 32'h5);
    tick(4);
    dsack_in = 2'b01;
    tick(1);
    check("a24_hold", reqs(), 32'h5);
    check("a24_berr", 32'(cpu_berr), 32'h1);
    cpu_as   = 1'b1;
    dsack_in = 2'b11;
    tick(1);
    check("a24_end", reqs(), 32'h7);

    // A16 beats overlapping A40 window
    start(3'b001, 32'hFFFF0010);
    tick(1);
    check("prio_a16", reqs(), 32'h3);
    cpu_as = 1'b1;
    tick(1);
    check("prio_end", reqs(), 32'h7);

    // Timeout on A40
    start(3'b101, 32'h80000000);
    tick(1);
    check("to_req", reqs(), 32'h6);
    tick(TO - 1);
    check("to_pre_req",  reqs(), 32'h6);
    check("to_pre_berr", 32'(cpu_berr), 32'h1);
    tick(1);
    check("to_req_off", reqs(), 32'h7);
    check("to_berr",    32'(cpu_berr), 32'h0);
    check("to_flag",    32'(timeout_flag), 32'h1);
    check("to_taddr",   timeout_address, 32'h80000000);
    tick(3);
    check("to_berr_hold", 32'(cpu_berr), 32'h0);
    cpu_as = 1'b1;
    tick(1);
    check("to_berr_rel", 32'(cpu_berr), 32'h1);

    // Misses: IACK and unmapped address
    start(3'b111, 32'hFE001234);
    tick(3);
    check("iack_noreq", reqs(), 32'h7);
    cpu_as = 1'b1;
    tick(1);
    start(3'b101, 32'h00001000);
    tick(2);
    check("miss_noreq", reqs(), 32'h7);
    cpu_as = 1'b1;
    tick(1);
    start(3'b101, 32'hFE000000);
    tick(1);
    check("miss_idle", reqs(), 32'h5);
    cpu_as = 1'b1;
    tick(1);

    // DSACK freezes the watchdog
    start(3'b101, 32'hC0000000);
    tick(1);
    tick(100);
    dsack_in = 2'b10;
    tick(1500);
    check("frz_berr", 32'(cpu_berr), 32'h1);
    check("frz_req",  reqs(), 32'h6);
    dsack_in = 2'b11;
    tick(TO - 101);
    check("frz_pre", 32'(cpu_berr), 32'h1);
    tick(1);
    check("frz_to", 32'(cpu_berr), 32'h0);
    cpu_as = 1'b1;
    tick(1);

    // Reset mid-ACTIVE at counter 500
    start(3'b101, 32'h80000000);
    tick(1);
    tick(500);
    reset = 1'b1;
    tick(1);
    check("mid_rst_req",  reqs(), 32'h7);
    check("mid_rst_flag", 32'(timeout_flag), 32'h0);
    reset = 1'b0;
    tick(3);
    check("as_low_norelaunch", reqs(), 32'h7);
    cpu_as = 1'b1;
    tick(1);
    start(3'b101, 32'h90000004);
    tick(1);
    check("post_rst_req", reqs(), 32'h6);
    tick(TO - 1);
    check("post_rst_pre", 32'(cpu_berr), 32'h1);
    timeout_clear = 1'b1;
    tick(1);
    timeout_clear = 1'b0;
    check("post_rst_to",  32'(cpu_berr), 32'h0);
    check("clr_vs_set",   32'(timeout_flag), 32'h1);
    check("post_rst_adr", timeout_address, 32'h90000004);
    cpu_as = 1'b1;
    tick(1);
    timeout_clear = 1'b1;
    tick(1);
    timeout_clear = 1'b0;
    check("clr_flag",   32'(timeout_flag), 32'h0);
    check("clr_keepad", timeout_address, 32'h90000004);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
